riscv_multicycle_ctrl: RTL
==========================

Name: riscv_multicycle_ctrl

Overview:
Main control unit of the RISC-V multi-cycle core.
- A Moore FSM plus combinational ALU and immediate decoders sequences the shared datapath: PC, IR, unified memory, register file and a single ALU.
- Receives opcode, funct3, funct7[5] and the ALU zero flag from the datapath.
- Drives every enable and mux select for the datapath, once per step of each instruction.
- Sits beside the datapath inside the core top, below the GPIO/device memory map.

Parameters:
- RESET_STATE_HOLD, 1, when 1 all write enables are held at 0 while reset is asserted.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero  in  1  ALU zero flag, valid in the same cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write enable.
- ir_write  out  1  IR and OldPC enable.
- reg_write  out  1  register-file write enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = Imm, 10 = constant 4.
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- illegal_instr  out  1  one-cycle pulse when an opcode is unsupported.

Behaviour:
- State register resets asynchronously to FETCH.
- While reset = 0: pc_write, ir_write, mem_write, reg_write and illegal_instr are all 0; the other outputs show FETCH values.
- Unlisted outputs in a state are 0; alu_op defaults to 00.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1. Next: DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> FETCH, with illegal_instr=1 for this cycle and no writes.
- MEMADR: alu_src_a=10, alu_src_b=01. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: result_src=00, adr_src=1. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1. Next: ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
- pc_write = pc_update | (branch & zero), combinational.
- ALU decoder (combinational):
  - alu_op 00 -> add; 01 -> sub.
  - alu_op 10 decodes funct3: 000 -> sub if {opcode[5], funct7b5} = 11, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- imm_src decodes from opcode in every state:
  - lw and I-type -> 000; sw -> 001; beq -> 010; jal -> 011; U-type -> 100 (only with the optional feature); others -> 000.
- Latency in cycles: lw 5; sw, R-type, I-type and jal 4; beq 3; illegal opcode 2.
- Reset mid-instruction aborts immediately; no partial write occurs after reset asserts.
- zero is sampled only in BEQ.

Optional Feature:
RV_CTRL_UPPER_IMM_EN
- Defined: adds state UPPER, entered from DECODE on LUI (0110111) or AUIPC (0010111).
  - UPPER: alu_src_b=01, alu_op=00, imm_src=100; alu_src_a=11 for LUI, 01 for AUIPC. Next: ALUWB.
  - LUI and AUIPC take 4 cycles.
- Undefined: both opcodes are illegal (illegal_instr pulse, 2 cycles); imm_src never equals 100.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enumeration and encodings;
  - opcode constants;
  - alu_control, result_src, alu_src_a/b and imm_src encodings.
- One sub-module: riscv_alu_decoder (alu_op, funct3, opcode[5], funct7b5 -> alu_control), purely combinational.

Test Plan:
1. Reset low for 2 cycles, then release -> all write enables 0 during reset; ir_write=1 and pc_write=1 on the first cycle after release.
2. add x3,x1,x2 (0x002081B3) -> states FETCH, DECODE, EXECUTER, ALUWB; alu_control=000; reg_write=1 in cycle 4 only.
3. sub x3,x1,x2 (0x402081B3) -> alu_control=001 in EXECUTER.
4. lw x5,4(x0) (0x00402283), then sw x5,8(x0) (0x00502423):
   - lw takes 5 cycles, adr_src=1 in MEMREAD, reg_write in MEMWB, imm_src=000;
   - sw takes 4 cycles, mem_write=1 in MEMWRITE, imm_src=001.
5. beq x0,x0,8 (0x00000463):
   - with zero=1 -> pc_write=1 in BEQ, alu_control=001, 3 cycles;
   - repeated with zero=0 -> pc_write=0 in BEQ.
6. Opcode 0x7F -> illegal_instr pulses in DECODE and the next state is FETCH. Also apply LUI 0x123452B7:
   - with RV_CTRL_UPPER_IMM_EN: UPPER then ALUWB, alu_src_a=11;
   - without it: illegal_instr pulses.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RISC-V multi-cycle control unit.
// Optional macro RV_CTRL_UPPER_IMM_EN enables LUI/AUIPC support (U-type immediates).
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_UPPER    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

`ifdef RV_CTRL_UPPER_IMM_EN
  localparam bit UPPER_IMM_EN = 1'b1;
`else
  localparam bit UPPER_IMM_EN = 1'b0;
`endif

  // Immediate format straight from the opcode; U-type only exists with the upper-immediate option.
  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:         imm = IMM_S;
      OP_BEQ:           imm = IMM_B;
      OP_JAL:           imm = IMM_J;
      OP_LUI, OP_AUIPC: imm = UPPER_IMM_EN ? IMM_U : IMM_I;
      default:          imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU decoder: alu_op plus instruction fields to alu_control.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op_b5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  // Select ALU operation; subtract on funct3=000 only for R-type with funct7[5] set.
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op_b5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the RISC-V multi-cycle core (Moore outputs, async active-low reset).
// Optional macro RV_CTRL_UPPER_IMM_EN adds the UPPER state for LUI/AUIPC.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit RESET_STATE_HOLD = 1'b1
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal_instr
);

  state_t     r_state;
  state_t     w_next;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic [1:0] w_alu_op;
  logic       w_hold;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next state and per-state control values.
  always_comb begin
    w_next      = S_FETCH;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    w_alu_op    = ALUOP_ADD;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = 1'b1;
        w_pc_update = 1'b1;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALURESULT;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_JAL:            w_next = S_JAL;
          OP_BEQ:            w_next = S_BEQ;
`ifdef RV_CTRL_UPPER_IMM_EN
          OP_LUI, OP_AUIPC:  w_next = S_UPPER;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        w_alu_op  = ALUOP_SUB;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end
      S_UPPER: begin
        alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        w_next    = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are forced low while reset is held.
  assign w_hold        = RESET_STATE_HOLD & ~reset;
  assign pc_write      = ~w_hold & (w_pc_update | (w_branch & zero));
  assign ir_write      = ~w_hold & w_ir_write;
  assign mem_write     = ~w_hold & w_mem_write;
  assign reg_write     = ~w_hold & w_reg_write;
  assign illegal_instr = ~w_hold & w_illegal;
  assign imm_src       = imm_decode(opcode);

  riscv_alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op_b5       (opcode[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (alu_control)
  );

endmodule
